// File: rtl/operand_pair_pipe.sv
// Operand-pair builder: stages halves a/b from one shared value bus, then queues
// complete {a, b} pairs in a DEPTH-entry elastic buffer with a valid/ready output.
module operand_pair_pipe #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               value,
  input  logic                       load_a,
  input  logic                       load_b,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic [2*N-1:0]             out,
  output logic                       out_valid,
  output logic                       stage_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           a_vld_r;
  logic           b_vld_r;
  logic [2*N-1:0] mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           full_r;
  logic           valid_r;

  logic           enq_s;
  logic           pop_s;
  logic [CW-1:0]  count_nxt_s;

  // Wrap explicitly at DEPTH-1 so non-power-of-2 depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake qualifiers derived only from registered state and out_ready.
  always_comb begin
    enq_s = a_vld_r & b_vld_r & ~full_r;
    pop_s = valid_r & out_ready;
  end

  // Next occupancy; simultaneous enqueue and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Staging halves; a load in the enqueue cycle overrides the flag clear.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      a_vld_r <= 1'b0;
      b_vld_r <= 1'b0;
    end else begin
      if (enq_s) begin
        a_vld_r <= 1'b0;
        b_vld_r <= 1'b0;
      end
      if (load_a) begin
        a_r     <= value;
        a_vld_r <= 1'b1;
      end
      if (load_b) begin
        b_r     <= value;
        b_vld_r <= 1'b1;
      end
    end
  end

  // Queue storage, written with the pre-edge staged pair.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*N){1'b0}};
      end
    end else if (enq_s) begin
      mem_r[wr_ptr_r] <= {a_r, b_r};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and the registered full/valid flags.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      valid_r <= (count_nxt_s != {CW{1'b0}});
    end
  end

  // Head mux over registered entries; zero while empty.
  always_comb begin
    if (valid_r) begin
      out = mem_r[rd_ptr_r];
    end else begin
      out = {(2*N){1'b0}};
    end
  end

  assign out_valid  = valid_r;
  assign stage_full = a_vld_r & b_vld_r;
  assign count      = count_r;
  assign full       = full_r;

  operand_pair_pipe_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .count      (count_r),
    .full       (full_r),
    .out_valid  (valid_r),
    .stage_full (stage_full)
  );

endmodule

// Invariant checker for the queue flags and occupancy.
module operand_pair_pipe_chk #(
  parameter int DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst,
  input logic [$clog2(DEPTH+1)-1:0] count,
  input logic                       full,
  input logic                       out_valid,
  input logic                       stage_full
);

  localparam int CW = $clog2(DEPTH + 1);

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH));

  a_full_flag: assert property (@(posedge clk) disable iff (!rst)
    full == (count == CW'(DEPTH)));

  a_valid_flag: assert property (@(posedge clk) disable iff (!rst)
    out_valid == (count != {CW{1'b0}}));

  a_stage_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(stage_full));

endmodule

// File: tb/tb_operand_pair_pipe.sv
// Directed bench for operand_pair_pipe: DEPTH=2 instance for most scenarios,
// a DEPTH=3 instance sharing the inputs for the pointer-wrap scenario.
module tb_operand_pair_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  value = 8'h00;
  logic        load_a = 1'b0;
  logic        load_b = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic [15:0] out2;
  logic        out_valid2, stage_full2, full2;
  logic [1:0]  count2;
  logic [15:0] out3;
  logic        out_valid3, stage_full3, full3;
  logic [1:0]  count3;

  int n_pass = 0;
  int n_total = 0;
  logic mon_en = 1'b0;
  int widx = 0;
  logic [15:0] exp_wrap [7] = '{16'h1020, 16'h1121, 16'h1222, 16'h1323,
                                16'h1424, 16'h1525, 16'h1626};

  always #5 clk = ~clk;

  operand_pair_pipe #(.N(8), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .value(value), .load_a(load_a), .load_b(load_b),
    .flush(flush), .out_ready(out_ready), .out(out2), .out_valid(out_valid2),
    .stage_full(stage_full2), .count(count2), .full(full2)
  );

  operand_pair_pipe #(.N(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .value(value), .load_a(load_a), .load_b(load_b),
    .flush(flush), .out_ready(out_ready), .out(out3), .out_valid(out_valid3),
    .stage_full(stage_full3), .count(count3), .full(full3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    value = a; load_a = 1'b1; tick(); load_a = 1'b0;
    value = b; load_b = 1'b1; tick(); load_b = 1'b0;
  endtask

  // Pop monitor for the wrap scenario: head is stable between edges.
  always @(negedge clk) begin
    if (mon_en && out_valid3 && out_ready && widx < 7) begin
      check("wrap_order", {16'h0, out3}, {16'h0, exp_wrap[widx]});
      widx++;
    end
  end

  initial begin
    // Reset with a load pending.
    rst = 1'b0; load_a = 1'b1; value = 8'hFF;
    repeat (3) tick();
    check("rst_out", out2, 16'h0000);
    check("rst_valid", out_valid2, 1'b0);
    check("rst_stage", stage_full2, 1'b0);
    check("rst_count", count2, 2'd0);
    check("rst_full", full2, 1'b0);
    rst = 1'b1; load_a = 1'b0;
    repeat (2) tick();
    check("idle_all", {out2, out_valid2, stage_full2, count2, full2}, 32'h0);

    // Basic pair with out_ready high.
    out_ready = 1'b1;
    load_pair(8'h12, 8'h34);
    check("basic_stage", stage_full2, 1'b1);
    check("basic_novalid", out_valid2, 1'b0);
    tick();
    check("basic_stage_clr", stage_full2, 1'b0);
    check("basic_out", {out_valid2, out2}, 17'h11234);
    tick();
    check("basic_pop", {out_valid2, count2, out2}, 32'h0);

    // Backpressure until full, then drain in order.
    out_ready = 1'b0;
    load_pair(8'h01, 8'h02);
    load_pair(8'h03, 8'h04);
    load_pair(8'h05, 8'h06);
    tick();
    check("bp_full", full2, 1'b1);
    check("bp_count", count2, 2'd2);
    check("bp_stage", stage_full2, 1'b1);
    check("bp_head0", out2, 16'h0102);
    out_ready = 1'b1;
    tick();
    check("bp_head1", out2, 16'h0304);
    check("bp_cnt1", count2, 2'd1);
    tick();
    check("bp_head2", out2, 16'h0506);
    check("bp_cnt_same", count2, 2'd1);
    check("bp_stage_clr", stage_full2, 1'b0);
    tick();
    check("bp_drained", {out_valid2, count2}, 3'b000);

    // Simultaneous enqueue, pop and load_a.
    out_ready = 1'b0;
    load_pair(8'h77, 8'h88);
    tick();
    load_pair(8'h99, 8'h66);
    check("sim_pre", {count2, stage_full2}, 3'b011);
    out_ready = 1'b1; load_a = 1'b1; value = 8'hAA;
    tick();
    load_a = 1'b0;
    check("sim_count", count2, 2'd1);
    check("sim_head", out2, 16'h9966);
    check("sim_stage", stage_full2, 1'b0);
    value = 8'hBB; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    check("sim_restage", {count2, stage_full2}, 3'b001);
    tick();
    check("sim_newa", out2, 16'hAABB);
    tick();

    // Overwrite and dual load.
    value = 8'h11; load_a = 1'b1; tick();
    value = 8'h22; tick(); load_a = 1'b0;
    value = 8'h33; load_b = 1'b1; tick(); load_b = 1'b0;
    tick();
    check("ovw_pair", out2, 16'h2233);
    tick();
    value = 8'h44; load_a = 1'b1; load_b = 1'b1; tick();
    load_a = 1'b0; load_b = 1'b0;
    check("dual_stage", stage_full2, 1'b1);
    tick();
    check("dual_pair", out2, 16'h4444);
    tick();

    // Flush a full queue with pop and load_b asserted.
    out_ready = 1'b0;
    load_pair(8'hA1, 8'hB1);
    load_pair(8'hA2, 8'hB2);
    tick();
    check("fl_pre_full", {full2, count2}, 3'b110);
    flush = 1'b1; out_ready = 1'b1; load_b = 1'b1; value = 8'h55;
    tick();
    flush = 1'b0; load_b = 1'b0;
    check("fl_clear", {out_valid2, stage_full2, count2, full2}, 5'b0);
    check("fl_clear3", {out_valid3, stage_full3, count3, full3}, 5'b0);
    value = 8'h66; load_a = 1'b1; tick(); load_a = 1'b0;
    check("fl_bvld_clr", stage_full2, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;

    // Seven pairs through DEPTH=3: pointers wrap twice.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) load_pair(8'h10 + 8'(i), 8'h20 + 8'(i));
    tick();
    check("wrap_full3", {full3, count3}, 3'b111);
    mon_en = 1'b1; out_ready = 1'b1;
    for (int i = 3; i < 7; i++) load_pair(8'h10 + 8'(i), 8'h20 + 8'(i));
    for (int t = 0; t < 40 && widx < 7; t++) tick();
    tick();
    check("wrap_all_popped", widx, 7);
    check("wrap_empty3", {out_valid3, count3}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
